mips_data_mem_ctrl: RTL and testbench

- Load/store controller between the MIPS MEM stage and a single-port synchronous data RAM with one-cycle read latency.
- Accepts one byte, half-word or word access at a time.
- Checks alignment and converts the MIPS virtual address to a RAM word index.
- Sub-word stores are done as a read-modify-write; loads return sign- or zero-extended data.

---
 rtl/mips_mem_pkg.sv | 29 ++
 rtl/mips_lane_align.sv | 42 ++++
 rtl/mips_data_mem_ctrl.sv | 123 ++++++++++++
 tb/tb_mips_data_mem_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings, FSM states and helpers for the MIPS data-memory controller.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DATA_BASE_DEF   = 32'h1001_0000;
  localparam int          WORD_OFFSET_DEF = 192;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_RESP,
    ST_ERR
  } state_t;

  // Size 11 is illegal and falls under the word rule.
  function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~addr_lo[0];
      default: is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mips_lane_align.sv
// Little-endian lane handling: load extract/extend and store-lane merge.
module mips_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bsh  = {i_lane, 3'b000};
  assign w_hsh  = {i_lane[1], 4'b0000};
  assign w_byte = i_rdata[w_bsh +: 8];
  assign w_half = i_rdata[w_hsh +: 16];

  always_comb begin
    o_load  = i_rdata;
    o_merge = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_load              = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merge             = i_rdata;
        o_merge[w_bsh +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load               = {{16{i_signed & w_half[15]}}, w_half};
        o_merge              = i_rdata;
        o_merge[w_hsh +: 16] = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_data_mem_ctrl.sv
// Load/store controller between the MIPS MEM stage and a 1-cycle-latency data RAM.
module mips_data_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    MEM_ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] DATA_BASE      = DATA_BASE_DEF,
  parameter int                    WORD_OFFSET    = WORD_OFFSET_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      addr_err,
  output logic [ADDR_WIDTH-1:0]     bad_vaddr,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [MEM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic [DATA_WIDTH-1:0]     ram_rdata
);

  state_t                    r_state, w_next;
  logic [MEM_ADDR_WIDTH-1:0] r_idx;
  logic [1:0]                r_lane;
  logic [1:0]                r_size;
  logic                      r_we;
  logic                      r_signed;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH-1:0]     r_resp_rdata;
  logic [ADDR_WIDTH-1:0]     r_bad_vaddr;

  logic                      w_accept;
  logic                      w_aligned;
  logic                      w_subword;
  logic [MEM_ADDR_WIDTH-1:0] w_idx;
  logic [DATA_WIDTH-1:0]     w_load;
  logic [DATA_WIDTH-1:0]     w_merge;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_aligned = is_aligned(req_addr[1:0], req_size);
  assign w_subword = (req_size == SZ_BYTE) || (req_size == SZ_HALF);
  // Modular translation: addresses below DATA_BASE wrap without a range check.
  assign w_idx = MEM_ADDR_WIDTH'(((req_addr - DATA_BASE) >> 2) + ADDR_WIDTH'(WORD_OFFSET));

  mips_lane_align u_align (
    .i_lane   (r_lane),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_rdata  (ram_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!w_aligned)               w_next = ST_ERR;
          else if (req_we && !w_subword) w_next = ST_WR;
          else                          w_next = ST_RD;
        end
      end
      ST_RD:      w_next = ST_RD_WAIT;
      ST_RD_WAIT: w_next = r_we ? ST_WR : ST_RESP;
      ST_WR:      w_next = ST_RESP;
      ST_RESP:    w_next = ST_IDLE;
      ST_ERR:     w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_lane       <= '0;
      r_size       <= '0;
      r_we         <= 1'b0;
      r_signed     <= 1'b0;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
      r_bad_vaddr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx    <= w_idx;
        r_lane   <= req_addr[1:0];
        r_size   <= req_size;
        r_we     <= req_we;
        r_signed <= req_signed;
        r_wdata  <= req_wdata;
        // Captured at accept so bad_vaddr is already valid during the error pulse.
        if (!w_aligned) r_bad_vaddr <= req_addr;
      end
      if (r_state == ST_RD_WAIT) begin
        if (r_we) r_wdata      <= w_merge;
        else      r_resp_rdata <= w_load;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP) || (r_state == ST_ERR);
  assign addr_err   = (r_state == ST_ERR);
  assign ram_en     = ((r_state == ST_RD) || (r_state == ST_WR)) && !reset;
  assign ram_we     = (r_state == ST_WR) && !reset;
  assign ram_addr   = r_idx;
  assign ram_wdata  = r_wdata;
  assign resp_rdata = r_resp_rdata;
  assign bad_vaddr  = r_bad_vaddr;

endmodule

// File: tb/tb_mips_data_mem_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a word-array reference model.
module tb_mips_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, addr_err;
  logic [31:0] resp_rdata, bad_vaddr;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  mips_data_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .addr_err(addr_err), .bad_vaddr(bad_vaddr),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Bench RAM: synchronous, one-cycle read latency.
  logic [31:0] ram [1024];
  logic [31:0] ram_q;
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'(i) * 32'h9E37_79B9;
      ram_q <= 32'h0;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_q <= ram[ram_addr];
    end
  end
  assign ram_rdata = ram_q;

  // Reference model of the RAM contents, at word granularity.
  logic [31:0] model [1024];
  int vectors = 0;
  int miscompares = 0;

  int          t_lat, t_en_cnt, t_wr_cnt, t_rd_cnt;
  logic        t_err, t_ready;
  logic [31:0] t_rdata, t_bad, t_wr_data;
  logic [9:0]  t_wr_addr, t_rd_addr;

  function automatic int unsigned idx_of(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'h1001_0000;
    return ((d / 4) + 192) % 1024;
  endfunction

  function automatic bit ref_aligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit sgn);
    logic [31:0] w, v;
    int sh;
    w = model[idx_of(a)];
    if (sz == 2'd0) begin
      sh = 8 * (a % 4);
      v = (w >> sh) & 32'hFF;
      if (sgn && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      sh = 16 * ((a % 4) / 2);
      v = (w >> sh) & 32'hFFFF;
      if (sgn && v >= 32768) v = v - 65536;
    end else v = w;
    return v;
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    int unsigned i;
    int sh;
    i = idx_of(a);
    if (sz == 2'd0) begin
      sh = 8 * (a % 4);
      mask = 32'hFF << sh;
      model[i] = (model[i] & ~mask) | ((d & 32'hFF) << sh);
    end else if (sz == 2'd1) begin
      sh = 16 * ((a % 4) / 2);
      mask = 32'hFFFF << sh;
      model[i] = (model[i] & ~mask) | ((d & 32'hFFFF) << sh);
    end else model[i] = d;
  endfunction

  // Issues one request and observes RAM activity until the response (bounded).
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    t_ready = req_ready;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    // Scramble request inputs while busy; the controller must ignore them.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    t_lat = 0; t_en_cnt = 0; t_wr_cnt = 0; t_rd_cnt = 0; t_err = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ram_en) begin
        t_en_cnt++;
        if (ram_we) begin t_wr_cnt++; t_wr_addr = ram_addr; t_wr_data = ram_wdata; end
        else begin t_rd_cnt++; t_rd_addr = ram_addr; end
      end
      if (resp_valid) begin
        t_lat = c; t_err = addr_err; t_rdata = resp_rdata; t_bad = bad_vaddr;
        break;
      end
    end
    vectors++;
    if (t_lat == 0) begin
      miscompares++;
      $display("FAIL timeout: no resp_valid within 10 cycles for addr %h", a);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, addr_err, ram_en} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rdy/vld/err/en=%b want 1000", {req_ready, resp_valid, addr_err, ram_en});
    end
    vectors++;
    if (resp_rdata !== 32'h0 || bad_vaddr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got rdata=%h bad=%h want 0/0", resp_rdata, bad_vaddr);
    end
  endtask

  task automatic test_word();
    run_txn(1'b1, 2'd2, 1'b0, 32'h1001_0000, 32'hDEAD_BEEF);
    ref_store(32'h1001_0000, 2'd2, 32'hDEAD_BEEF);
    vectors++;
    if (t_lat != 2 || t_wr_cnt != 1 || t_en_cnt != 1 || t_wr_addr !== 10'd192 || t_wr_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL sw: got lat=%0d wr=%0d en=%0d addr=%0d data=%h want 2/1/1/192/deadbeef",
               t_lat, t_wr_cnt, t_en_cnt, t_wr_addr, t_wr_data);
    end
    vectors++;
    if (t_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_idle: got %b want 1", t_ready);
    end
    run_txn(1'b0, 2'd2, 1'b0, 32'h1001_0000, 32'h0);
    vectors++;
    if (t_lat != 3 || t_rdata !== 32'hDEAD_BEEF || t_rd_addr !== 10'd192) begin
      miscompares++;
      $display("FAIL lw: got lat=%0d data=%h addr=%0d want 3/deadbeef/192", t_lat, t_rdata, t_rd_addr);
    end
  endtask

  task automatic test_byte_loads();
    run_txn(1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'h1122_3344);
    ref_store(32'h1001_0004, 2'd2, 32'h1122_3344);
    run_txn(1'b0, 2'd0, 1'b1, 32'h1001_0007, 32'h0);
    vectors++;
    if (t_lat != 3 || t_rdata !== 32'h0000_0011) begin
      miscompares++;
      $display("FAIL lb_pos: got lat=%0d data=%h want 3/00000011", t_lat, t_rdata);
    end
    run_txn(1'b1, 2'd0, 1'b0, 32'h1001_0007, 32'hFFFF_FF80);
    ref_store(32'h1001_0007, 2'd0, 32'hFFFF_FF80);
    vectors++;
    if (t_lat != 4 || t_wr_data !== 32'h8022_3344 || t_rd_cnt != 1) begin
      miscompares++;
      $display("FAIL sb: got lat=%0d data=%h rd=%0d want 4/80223344/1", t_lat, t_wr_data, t_rd_cnt);
    end
    run_txn(1'b0, 2'd0, 1'b1, 32'h1001_0007, 32'h0);
    vectors++;
    if (t_rdata !== 32'hFFFF_FF80) begin
      miscompares++;
      $display("FAIL lb_neg: got %h want ffffff80", t_rdata);
    end
    run_txn(1'b0, 2'd0, 1'b0, 32'h1001_0007, 32'h0);
    vectors++;
    if (t_rdata !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL lbu: got %h want 00000080", t_rdata);
    end
  endtask

  task automatic test_half_store();
    run_txn(1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'h1122_3344);
    ref_store(32'h1001_0004, 2'd2, 32'h1122_3344);
    run_txn(1'b1, 2'd1, 1'b0, 32'h1001_0006, 32'h0000_ABCD);
    ref_store(32'h1001_0006, 2'd1, 32'h0000_ABCD);
    vectors++;
    if (t_lat != 4 || t_wr_data !== 32'hABCD_3344 || t_wr_addr !== 10'd193 || t_rd_addr !== 10'd193) begin
      miscompares++;
      $display("FAIL sh: got lat=%0d data=%h waddr=%0d raddr=%0d want 4/abcd3344/193/193",
               t_lat, t_wr_data, t_wr_addr, t_rd_addr);
    end
    run_txn(1'b0, 2'd1, 1'b1, 32'h1001_0006, 32'h0);
    vectors++;
    if (t_rdata !== 32'hFFFF_ABCD) begin
      miscompares++;
      $display("FAIL lh_neg: got %h want ffffabcd", t_rdata);
    end
  endtask

  task automatic test_misalign();
    run_txn(1'b0, 2'd2, 1'b0, 32'h1001_0002, 32'h0);
    vectors++;
    if (t_lat != 1 || t_err !== 1'b1 || t_bad !== 32'h1001_0002 || t_en_cnt != 0) begin
      miscompares++;
      $display("FAIL lw_misalign: got lat=%0d err=%b bad=%h en=%0d want 1/1/10010002/0", t_lat, t_err, t_bad, t_en_cnt);
    end
    run_txn(1'b0, 2'd1, 1'b0, 32'h1001_0001, 32'h0);
    vectors++;
    if (t_err !== 1'b1 || t_bad !== 32'h1001_0001) begin
      miscompares++;
      $display("FAIL lh_misalign: got err=%b bad=%h want 1/10010001", t_err, t_bad);
    end
    run_txn(1'b1, 2'd3, 1'b0, 32'h1001_0006, 32'h5555_5555);
    vectors++;
    if (t_err !== 1'b1 || t_wr_cnt != 0) begin
      miscompares++;
      $display("FAIL sw_misalign: got err=%b writes=%0d want 1/0", t_err, t_wr_cnt);
    end
    run_txn(1'b0, 2'd0, 1'b0, 32'h1001_0003, 32'h0);
    vectors++;
    if (t_err !== 1'b0 || t_lat != 3 || t_rdata !== ref_load(32'h1001_0003, 2'd0, 1'b0) || t_bad !== 32'h1001_0006) begin
      miscompares++;
      $display("FAIL lb_aligned: got err=%b lat=%0d data=%h bad=%h want 0/3/%h/10010006",
               t_err, t_lat, t_rdata, t_bad, ref_load(32'h1001_0003, 2'd0, 1'b0));
    end
  endtask

  task automatic test_wrap();
    run_txn(1'b1, 2'd2, 1'b0, 32'h1000_FFFC, 32'hCAFE_F00D);
    ref_store(32'h1000_FFFC, 2'd2, 32'hCAFE_F00D);
    vectors++;
    if (t_wr_addr !== 10'd191 || t_lat != 2) begin
      miscompares++;
      $display("FAIL wrap: got addr=%0d lat=%0d want 191/2", t_wr_addr, t_lat);
    end
  endtask

  // Random back-to-back traffic; each request is issued in the cycle right after the response.
  task automatic test_back_to_back();
    logic [31:0] a, d, exp;
    logic [1:0]  sz;
    logic        we, sgn;
    for (int n = 0; n < 200; n++) begin
      a = 32'h1001_0000 + 32'($urandom_range(0, 511)) - 32'd64;
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom); sgn = 1'($urandom); d = $urandom;
      exp = ref_load(a, sz, sgn);
      run_txn(we, sz, sgn, a, d);
      vectors++;
      if (t_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready: got %b want 1 (txn %0d)", t_ready, n);
      end
      if (!ref_aligned(a, sz)) begin
        vectors++;
        if (t_lat != 1 || t_err !== 1'b1 || t_bad !== a || t_en_cnt != 0) begin
          miscompares++;
          $display("FAIL rnd_err: a=%h sz=%0d got lat=%0d err=%b bad=%h en=%0d want 1/1/%h/0",
                   a, sz, t_lat, t_err, t_bad, t_en_cnt, a);
        end
      end else if (we) begin
        ref_store(a, sz, d);
        vectors++;
        if (t_lat != ((sz < 2) ? 4 : 2) || t_err !== 1'b0 || t_wr_cnt != 1 ||
            t_wr_addr !== 10'(idx_of(a)) || t_wr_data !== model[idx_of(a)]) begin
          miscompares++;
          $display("FAIL rnd_st: a=%h sz=%0d got lat=%0d err=%b wr=%0d addr=%0d data=%h want %0d/0/1/%0d/%h",
                   a, sz, t_lat, t_err, t_wr_cnt, t_wr_addr, t_wr_data, (sz < 2) ? 4 : 2, idx_of(a), model[idx_of(a)]);
        end
      end else begin
        vectors++;
        if (t_lat != 3 || t_err !== 1'b0 || t_rdata !== exp || t_rd_addr !== 10'(idx_of(a))) begin
          miscompares++;
          $display("FAIL rnd_ld: a=%h sz=%0d s=%b got lat=%0d err=%b data=%h addr=%0d want 3/0/%h/%0d",
                   a, sz, sgn, t_lat, t_err, t_rdata, t_rd_addr, exp, idx_of(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h1001_0020; req_wdata = ~model[200];
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (ram_we !== 1'b0 || ram_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wr_gate: got we=%b en=%b want 0/0", ram_we, ram_en);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, addr_err} !== 3'b100 || bad_vaddr !== 32'h0 || resp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid: got rdy/vld/err=%b bad=%h rdata=%h want 100/0/0",
               {req_ready, resp_valid, addr_err}, bad_vaddr, resp_rdata);
    end
    vectors++;
    if (ram[200] !== model[200]) begin
      miscompares++;
      $display("FAIL rst_no_write: got ram=%h want %h", ram[200], model[200]);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_resp: got %b want 0", resp_valid);
    end
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) model[i] = 32'(i) * 32'h9E37_79B9;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; mem_clr = 1'b0;
    test_reset();
    test_word();
    test_byte_loads();
    test_half_store();
    test_misalign();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
